// File: rtl/serial_mag_comparator_pkg.sv
// Shared types and helpers for the serial magnitude comparator.
// Chunk width, FSM states, default cascade seed.
package cmp_pkg;

    localparam int CHUNK_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    // Cascade bits are ordered {l, e, g}.
    localparam logic [2:0] SEED_EQ = 3'b010;

    function automatic logic onehot3(input logic [2:0] v);
        return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
    endfunction

endpackage

// File: rtl/serial_mag_comparator_if.sv
// Request/result bundle of the serial magnitude comparator.
// master drives operands and start, slave returns status and result.
interface serial_mag_comparator_if #(
    parameter int W = 12
);

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         seed_l;
    logic         seed_e;
    logic         seed_g;
    logic         busy;
    logic         done;
    logic         lt;
    logic         eq;
    logic         gt;

    modport master (
        output start, a, b, seed_l, seed_e, seed_g,
        input  busy, done, lt, eq, gt
    );

    modport slave (
        input  start, a, b, seed_l, seed_e, seed_g,
        output busy, done, lt, eq, gt
    );

endinterface

// File: rtl/serial_mag_comparator_comparator3.sv
// 3-bit magnitude comparator slice with l/e/g cascade input.
// Unequal chunks decide; equal chunks pass the cascade through.
module comparator3
    import cmp_pkg::*;
(
    input  logic [CHUNK_W-1:0] A,
    input  logic [CHUNK_W-1:0] B,
    input  logic               l,
    input  logic               e,
    input  logic               g,
    output logic               lt,
    output logic               eq,
    output logic               gt
);

    // Local chunk compare overrides the cascade when unequal.
    always_comb begin
        lt = 1'b0;
        eq = 1'b0;
        gt = 1'b0;
        if (A > B) begin
            gt = 1'b1;
        end else if (A < B) begin
            lt = 1'b1;
        end else begin
            lt = l;
            eq = e;
            gt = g;
        end
    end

endmodule

// File: rtl/serial_mag_comparator.sv
// Wide magnitude comparator using one time-multiplexed 3-bit slice.
// Chunks are walked LSB-first; the cascade is carried in a register.
module serial_mag_comparator
    import cmp_pkg::*;
#(
    parameter int CHUNKS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    serial_mag_comparator_if.slave   bus
);

    localparam int W     = CHUNK_W * CHUNKS;
    localparam int IDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(CHUNKS - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [2:0]         casc_q, casc_d;
    logic [2:0]         res_q, res_d;

    logic [CHUNK_W-1:0] a_c;
    logic [CHUNK_W-1:0] b_c;
    logic               s_lt, s_eq, s_gt;
    logic [2:0]         seed_in;
    logic [2:0]         seed_ok;

    // Select the current chunk of the latched operands.
    always_comb begin
        a_c = '0;
        b_c = '0;
        for (int i = 0; i < CHUNKS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_c = a_q[i*CHUNK_W +: CHUNK_W];
                b_c = b_q[i*CHUNK_W +: CHUNK_W];
            end
        end
    end

    comparator3 u_slice (
        .A  (a_c),
        .B  (b_c),
        .l  (casc_q[2]),
        .e  (casc_q[1]),
        .g  (casc_q[0]),
        .lt (s_lt),
        .eq (s_eq),
        .gt (s_gt)
    );

    assign seed_in = {bus.seed_l, bus.seed_e, bus.seed_g};
    assign seed_ok = onehot3(seed_in) ? seed_in : SEED_EQ;

    // Next-state, chunk walk and result capture.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        casc_d  = casc_q;
        res_d   = res_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    state_d = RUN;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    idx_d   = '0;
                    casc_d  = seed_ok;
                end
            end
            RUN: begin
                casc_d = {s_lt, s_eq, s_gt};
                if (idx_q == LAST) begin
                    res_d   = {s_lt, s_eq, s_gt};
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared by async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            casc_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            casc_q  <= casc_d;
            res_q   <= res_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.lt   = res_q[2];
    assign bus.eq   = res_q[1];
    assign bus.gt   = res_q[0];

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Directed bench for serial_mag_comparator (CHUNKS=4, W=12).
// Vector table plus handshake and reset-abort sequences.
module tb_serial_mag_comparator;

    typedef struct {
        logic [11:0] a;
        logic [11:0] b;
        logic [2:0]  seed;
        logic [2:0]  res;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [2:0] last_res = 3'b000;

    serial_mag_comparator_if #(.W(12)) bus ();

    serial_mag_comparator #(.CHUNKS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [2:0] outs();
        return {bus.lt, bus.eq, bus.gt};
    endfunction

    task automatic run_vec(input vec_t v, input int k);
        int  lat;
        bit  got;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = v.a;
        bus.b = v.b;
        {bus.seed_l, bus.seed_e, bus.seed_g} = v.seed;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a = ~v.a;
        bus.b = ~v.b;
        {bus.seed_l, bus.seed_e, bus.seed_g} = 3'b000;
        lat = 0;
        got = 0;
        while (!got && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.done) begin
                got = 1;
            end else begin
                chk($sformatf("hold[%0d]", k), 32'(outs()), 32'(last_res));
                chk($sformatf("busy[%0d]", k), 32'(bus.busy), 32'(1));
            end
        end
        chk($sformatf("latency[%0d]", k), 32'(lat), 32'(4));
        chk($sformatf("result[%0d]", k), 32'(outs()), 32'(v.res));
        last_res = v.res;
        @(negedge clk);
        chk($sformatf("pulse[%0d]", k), 32'(bus.done), 32'(0));
        chk($sformatf("keep[%0d]", k), 32'(outs()), 32'(v.res));
    endtask

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{12'h001, 12'h001, 3'b010, 3'b010};
        vecs[1]  = '{12'h001, 12'h001, 3'b100, 3'b100};
        vecs[2]  = '{12'h001, 12'h001, 3'b001, 3'b001};
        vecs[3]  = '{12'h002, 12'h001, 3'b100, 3'b001};
        vecs[4]  = '{12'h002, 12'h001, 3'b010, 3'b001};
        vecs[5]  = '{12'h002, 12'h001, 3'b001, 3'b001};
        vecs[6]  = '{12'h001, 12'h002, 3'b010, 3'b100};
        vecs[7]  = '{12'h800, 12'h7FF, 3'b010, 3'b001};
        vecs[8]  = '{12'h0C7, 12'h100, 3'b010, 3'b100};
        vecs[9]  = '{12'h001, 12'h001, 3'b000, 3'b010};
        vecs[10] = '{12'h001, 12'h001, 3'b111, 3'b010};
        vecs[11] = '{12'hABC, 12'hABC, 3'b011, 3'b010};
        vecs[12] = '{12'h0C7, 12'h0C6, 3'b100, 3'b001};

        // Reset held with start asserted.
        bus.start = 1'b1;
        bus.a = 12'h001;
        bus.b = 12'h001;
        {bus.seed_l, bus.seed_e, bus.seed_g} = 3'b010;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'(0));
        chk("rst_done", 32'(bus.done), 32'(0));
        chk("rst_out", 32'(outs()), 32'(0));
        bus.start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_idle", 32'(bus.busy), 32'(0));

        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i], i);
        end

        // Start held 10 cycles; operands change while busy.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 12'd5;
        bus.b = 12'd3;
        {bus.seed_l, bus.seed_e, bus.seed_g} = 3'b010;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("hs_done[%0d]", c), 32'(bus.done),
                32'((c == 4) || (c == 9)));
            chk($sformatf("hs_busy[%0d]", c), 32'(bus.busy),
                32'((c < 4) || (c > 4 && c < 9)));
            if (c == 4 || c == 9) begin
                chk($sformatf("hs_res[%0d]", c), 32'(outs()), 32'(3'b001));
            end
            if (c == 1 || c == 6) begin
                bus.a = 12'd3;
                bus.b = 12'd5;
            end else if (c == 4) begin
                bus.a = 12'd5;
                bus.b = 12'd3;
            end
        end
        bus.start = 1'b0;
        last_res = 3'b001;
        repeat (2) @(negedge clk);

        // Reset pulse during RUN aborts the compare.
        bus.start = 1'b1;
        bus.a = 12'h001;
        bus.b = 12'h002;
        {bus.seed_l, bus.seed_e, bus.seed_g} = 3'b010;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ab_out", 32'(outs()), 32'(0));
        chk("ab_busy", 32'(bus.busy), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        last_res = 3'b000;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("ab_nodone[%0d]", c), 32'(bus.done), 32'(0));
        end
        run_vec('{12'h7, 12'h3, 3'b100, 3'b001}, 99);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
